// File: rtl/btn_conditioner_if.sv
// Pushbutton bundle: raw buttons from the board side (master) into the
// conditioner (slave), conditioned events back out.
interface btn_conditioner_if;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_hold;
  logic [4:0] btn_release;
  logic       btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_hold, btn_release, btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_hold, btn_release, btn_repeat
  );
endinterface

// File: rtl/btn_conditioner.sv
// Five independent debounce/press/hold/release channels behind 2-flop synchronisers.
// Optional auto-repeat on channel 0 is enabled with `define BTN_CONDITIONER_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 15_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  btn_conditioner_if.slave btn
);
  localparam int N     = 5;
  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_P = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, HELD, DB_RELEASE} state_e;

  localparam cnt_t DB_LAST   = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);

  logic [N-1:0] sync1_q, sync2_q;
  logic [1:0]   rst_sync_q;
  logic         run;

  state_e       state_q    [N];
  state_e       state_d    [N];
  cnt_t         db_cnt_q   [N];
  cnt_t         db_cnt_d   [N];
  cnt_t         hold_cnt_q [N];
  cnt_t         hold_cnt_d [N];
  logic [N-1:0] from_held_q, from_held_d;
  logic [N-1:0] level_q, level_d;
  logic [N-1:0] press_q, press_d;
  logic [N-1:0] hold_q, hold_d;
  logic [N-1:0] release_q, release_d;

  // FSMs stay parked in IDLE until reset release has crossed two flops.
  assign run = rst_sync_q[1];

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    for (int i = 0; i < N; i++) begin
      state_d[i]    = state_q[i];
      db_cnt_d[i]   = db_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
    end
    from_held_d = from_held_q;
    level_d     = level_q;
    press_d     = '0;
    hold_d      = '0;
    release_d   = '0;

    if (run) begin
      for (int i = 0; i < N; i++) begin
        unique case (state_q[i])
          IDLE: begin
            if (sync2_q[i]) begin
              state_d[i]  = DB_PRESS;
              db_cnt_d[i] = '0;
            end
          end
          DB_PRESS: begin
            if (!sync2_q[i]) begin
              state_d[i] = IDLE;
            end else if (db_cnt_q[i] == DB_LAST) begin
              state_d[i]    = PRESSED;
              press_d[i]    = 1'b1;
              level_d[i]    = 1'b1;
              hold_cnt_d[i] = '0;
            end else begin
              db_cnt_d[i] = db_cnt_q[i] + cnt_t'(1);
            end
          end
          PRESSED: begin
            if (!sync2_q[i]) begin
              state_d[i]     = DB_RELEASE;
              db_cnt_d[i]    = '0;
              from_held_d[i] = 1'b0;
            end else if (hold_cnt_q[i] == HOLD_LAST) begin
              state_d[i] = HELD;
              hold_d[i]  = 1'b1;
            end else begin
              hold_cnt_d[i] = hold_cnt_q[i] + cnt_t'(1);
            end
          end
          HELD: begin
            if (!sync2_q[i]) begin
              state_d[i]     = DB_RELEASE;
              db_cnt_d[i]    = '0;
              from_held_d[i] = 1'b1;
            end
          end
          DB_RELEASE: begin
            // A bounce back to 1 resumes where the press left off, hold count intact.
            if (sync2_q[i]) begin
              state_d[i] = from_held_q[i] ? HELD : PRESSED;
            end else if (db_cnt_q[i] == DB_LAST) begin
              state_d[i]   = IDLE;
              level_d[i]   = 1'b0;
              release_d[i] = 1'b1;
            end else begin
              db_cnt_d[i] = db_cnt_q[i] + cnt_t'(1);
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      rst_sync_q  <= '0;
      // NOTE: these per-channel arrays are plain flops, not RAM, so they take
      // the async reset like any other state and need no clearing sequence.
      for (int i = 0; i < N; i++) begin
        state_q[i]    <= IDLE;
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
      end
      from_held_q <= '0;
      level_q     <= '0;
      press_q     <= '0;
      hold_q      <= '0;
      release_q   <= '0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values.
      sync1_q     <= btn.btn_raw;
      sync2_q     <= sync1_q;
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      from_held_q <= from_held_d;
      level_q     <= level_d;
      press_q     <= press_d;
      hold_q      <= hold_d;
      release_q   <= release_d;
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_hold    = hold_q;
  assign btn.btn_release = release_q;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam cnt_t REP_LAST = cnt_t'(REPEAT_CYCLES - 1);

  cnt_t rep_cnt_q, rep_cnt_d;
  logic rep_q, rep_d;

  // First repeat coincides with the hold event; the count freezes while debouncing a release.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_d     = 1'b0;
    if (run) begin
      if (state_q[0] == PRESSED && state_d[0] == HELD) begin
        rep_d     = 1'b1;
        rep_cnt_d = '0;
      end else if (state_q[0] == HELD && state_d[0] == HELD) begin
        if (rep_cnt_q == REP_LAST) begin
          rep_d     = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + cnt_t'(1);
        end
      end else if (state_q[0] == IDLE) begin
        rep_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_d;
    end
  end

  assign btn.btn_repeat = rep_q;
`else
  assign btn.btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE=4, HOLD=10, REPEAT=5.
// Cycle c counts falling edges after the raw change; a raw change reaches an output at c=7.
module tb_btn_conditioner;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 5;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  btn_conditioner_if btn_if ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // {level, press, hold, release, repeat}
  function automatic logic [20:0] observed();
    return {btn_if.btn_level, btn_if.btn_press, btn_if.btn_hold,
            btn_if.btn_release, btn_if.btn_repeat};
  endfunction

  function automatic logic [20:0] pack(logic [4:0] lv, logic [4:0] pr,
                                       logic [4:0] ho, logic [4:0] re, logic rp);
    return {lv, pr, ho, re, rp};
  endfunction

  function automatic logic exp_repeat(int c, int first, int last);
    logic hit;
    hit = (c >= first) && (c <= last) && (((c - first) % R) == 0);
    return hit & REP_EN;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    btn_if.btn_raw = 5'b11111;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vectors++;
      if (observed() !== 21'h0) begin
        miscompares++;
        $display("FAIL reset_hold c=%0d: got %h want %h", c, observed(), 21'h0);
      end
    end
    btn_if.btn_raw = 5'b00000;
    reset = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vectors++;
      if (observed() !== 21'h0) begin
        miscompares++;
        $display("FAIL reset_release c=%0d: got %h want %h", c, observed(), 21'h0);
      end
    end
  endtask

  task automatic test_inc_hold();
    logic [20:0] exp;
    btn_if.btn_raw = 5'b00001;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      exp = pack((c >= 7 && c <= 36) ? 5'b00001 : 5'b00000,
                 (c == 7)  ? 5'b00001 : 5'b00000,
                 (c == 17) ? 5'b00001 : 5'b00000,
                 (c == 37) ? 5'b00001 : 5'b00000,
                 exp_repeat(c, 17, 32));
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL inc_hold c=%0d: got %h want %h", c, observed(), exp);
      end
      if (c == 30) btn_if.btn_raw = 5'b00000;
    end
  endtask

  task automatic test_glitch();
    btn_if.btn_raw = 5'b00100;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      vectors++;
      if (observed() !== 21'h0) begin
        miscompares++;
        $display("FAIL mode_glitch c=%0d: got %h want %h", c, observed(), 21'h0);
      end
      if (c == 3) btn_if.btn_raw = 5'b00000;
    end
  endtask

  task automatic test_bounce();
    logic [20:0] exp;
    btn_if.btn_raw = 5'b01000;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      exp = pack((c >= 7 && c <= 25) ? 5'b01000 : 5'b00000,
                 (c == 7)  ? 5'b01000 : 5'b00000,
                 (c == 20) ? 5'b01000 : 5'b00000,
                 (c == 26) ? 5'b01000 : 5'b00000,
                 1'b0);
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL start_stop_bounce c=%0d: got %h want %h", c, observed(), exp);
      end
      if (c == 12) btn_if.btn_raw = 5'b00000;
      if (c == 14) btn_if.btn_raw = 5'b01000;
      if (c == 19) btn_if.btn_raw = 5'b00000;
    end
  endtask

  task automatic test_simultaneous();
    logic [20:0] exp;
    btn_if.btn_raw = 5'b00110;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      exp = pack((c >= 7 && c <= 18) ? 5'b00110 : 5'b00000,
                 (c == 7)  ? 5'b00110 : 5'b00000,
                 5'b00000,
                 (c == 19) ? 5'b00110 : 5'b00000,
                 1'b0);
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL simultaneous c=%0d: got %h want %h", c, observed(), exp);
      end
      if (c == 12) btn_if.btn_raw = 5'b00000;
    end
  endtask

  task automatic test_reset_mid_press();
    logic [20:0] exp;
    btn_if.btn_raw = 5'b10000;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp = pack((c >= 7) ? 5'b10000 : 5'b00000,
                 (c == 7) ? 5'b10000 : 5'b00000,
                 5'b00000, 5'b00000, 1'b0);
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL reset_btn_press c=%0d: got %h want %h", c, observed(), exp);
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (observed() !== 21'h0) begin
      miscompares++;
      $display("FAIL async_reset_clear: got %h want %h", observed(), 21'h0);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (observed() !== 21'h0) begin
        miscompares++;
        $display("FAIL reset_low c=%0d: got %h want %h", c, observed(), 21'h0);
      end
    end
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp = pack((k >= 7 && k <= 14) ? 5'b10000 : 5'b00000,
                 (k == 7)  ? 5'b10000 : 5'b00000,
                 5'b00000,
                 (k == 15) ? 5'b10000 : 5'b00000,
                 1'b0);
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL reset_redebounce k=%0d: got %h want %h", k, observed(), exp);
      end
      if (k == 8) btn_if.btn_raw = 5'b00000;
    end
  endtask

  task automatic test_repeat();
    logic exp_rp;
    int   pulses = 0;
    int   exp_pulses;
    exp_pulses = REP_EN ? 7 : 0;
    btn_if.btn_raw = 5'b00001;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      exp_rp = exp_repeat(c, 17, 47);
      if (btn_if.btn_repeat === 1'b1) pulses++;
      vectors++;
      if (btn_if.btn_repeat !== exp_rp) begin
        miscompares++;
        $display("FAIL inc_repeat c=%0d: got %b want %b", c, btn_if.btn_repeat, exp_rp);
      end
      if (c == 45) btn_if.btn_raw = 5'b00000;
    end
    vectors++;
    if (pulses !== exp_pulses) begin
      miscompares++;
      $display("FAIL repeat_count: got %0d want %0d", pulses, exp_pulses);
    end
  endtask

  initial begin
    reset = 1'b0;
    btn_if.btn_raw = 5'b00000;
    test_reset();
    test_inc_hold();
    repeat (5) @(negedge clk);
    test_glitch();
    repeat (5) @(negedge clk);
    test_bounce();
    repeat (5) @(negedge clk);
    test_simultaneous();
    repeat (5) @(negedge clk);
    test_reset_mid_press();
    repeat (5) @(negedge clk);
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles required to accept a level change.
REQ-002 Parameter HOLD_CYCLES, default 15_000_000, cycles a debounced press must persist before a hold event.
REQ-003 Parameter REPEAT_CYCLES, default 25_000_000, auto-repeat period after hold (AUTOREPEAT_EN only).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 btn_raw  input  5  raw, unsynchronised pushbuttons [4]=reset_btn [3]=start_stop [2]=mode [1]=edit_shift [0]=inc; 1 = pressed.
REQ-007 btn_level  output  5  debounced level per button.
REQ-008 btn_press  output  5  one-cycle pulse per button on accepted press.
REQ-009 btn_hold  output  5  one-cycle pulse per button when press persists HOLD_CYCLES.
REQ-010 btn_release  output  5  one-cycle pulse per button on accepted release.
REQ-011 btn_repeat  output  1  one-cycle auto-repeat pulse for inc (bit 0) only.

Function
REQ-012 Each btn_raw bit SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value (2-cycle input latency).
REQ-013 Each of 5 channels SHALL run an independent FSM: IDLE, DB_PRESS, PRESSED, HELD, DB_RELEASE; channels never interact.
REQ-014 IDLE -> DB_PRESS when sync input = 1; counter cleared.
REQ-015 DB_PRESS: counter increments while input = 1; input = 0 returns to IDLE with no pulse; counter reaching DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-016 Entry to PRESSED SHALL assert btn_press for exactly one cycle and set btn_level = 1; hold counter cleared.
REQ-017 PRESSED: hold counter increments each cycle; reaching HOLD_CYCLES-1 -> HELD with one-cycle btn_hold.
REQ-018 PRESSED or HELD: sync input = 0 -> DB_RELEASE, debounce counter cleared.
REQ-019 DB_RELEASE: input = 1 returns to the originating state (PRESSED or HELD) with hold counter preserved and no pulses; counter reaching DEBOUNCE_CYCLES-1 -> IDLE, btn_level = 0, one-cycle btn_release.
REQ-020 btn_hold SHALL fire at most once per press; btn_press and btn_release exactly once per accepted press.
REQ-021 Counters SHALL be wide enough for the largest parameter, saturate never, and never wrap within a state.
REQ-022 Simultaneous presses on several channels SHALL produce pulses on each in the same cycles as if pressed alone.
REQ-023 Parameters of 1 SHALL be legal: transition occurs the cycle after entry.

Reset
REQ-024 reset = 0 SHALL asynchronously set all FSMs to IDLE, clear counters and synchronisers, drive btn_level, btn_press, btn_hold, btn_release = 0 and btn_repeat = 0.
REQ-025 reset asserted mid-press SHALL suppress any pending pulse; after release of reset a still-pressed button SHALL be re-debounced from IDLE.
REQ-026 Reset deassertion SHALL be synchronised internally (2-flop) before FSMs leave IDLE.

Configuration
REQ-027 Macro BTN_CONDITIONER_AUTOREPEAT_EN defined: in HELD, channel 0 SHALL pulse btn_repeat coincident with btn_hold and then every REPEAT_CYCLES cycles until leaving HELD; repeat counter frozen in DB_RELEASE and cleared on IDLE.
REQ-028 Macro undefined: btn_repeat SHALL be tied to 0 and no repeat counter is synthesised; all other behaviour unchanged.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5)
REQ-029 inc held 30 cycles then released -> btn_press[0] one cycle at sync+4, btn_hold[0] 10 cycles later, btn_release[0] 4 cycles after sync release, btn_level[0] high between.
REQ-030 mode glitch high 3 cycles -> no pulses, btn_level[2] stays 0.
REQ-031 start_stop pressed 12 cycles, 2-cycle bounce low, pressed 5 more -> one btn_press, one btn_hold, no extra release/press.
REQ-032 mode and edit_shift pressed same cycle -> btn_press[2] and btn_press[1] in the same cycle.
REQ-033 reset pulled low 2 cycles after btn_press[4] while held -> all outputs 0 at once; no btn_hold/btn_release; after reset high, new btn_press[4] after resync+debounce.
REQ-034 AUTOREPEAT_EN defined, inc held 30 cycles past hold -> btn_repeat at hold cycle then every 5 cycles (7 pulses); undefined -> btn_repeat constant 0.
